// File: rtl/lab2_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lab2_mem_pkg
//  Purpose  : Shared definitions for the lab2 memory responder.
//             - mem_req_4B_t / mem_resp_4B_t message layouts
//             - message type and length encodings
//             - responder FSM state encoding
//             - LFSR seed, taps and next-state helper for the optional
//               random-delay mode (LAB2_MEM_RESPONDER_RAND_DELAY_EN)
//  Revision : 1.0 - initial release
// ============================================================================
package lab2_mem_pkg;

    // Message type encodings. Anything above WRITE_INIT (AMOs etc.) is
    // rejected by the responder and flags err.
    localparam logic [2:0] c_MEM_TYPE_READ       = 3'd0;
    localparam logic [2:0] c_MEM_TYPE_WRITE      = 3'd1;
    localparam logic [2:0] c_MEM_TYPE_WRITE_INIT = 3'd2;
    localparam logic [2:0] c_MEM_TYPE_AMO_ADD    = 3'd3;

    // Length encodings. 0 and 3 both mean a full 32-bit word.
    localparam logic [1:0] c_MEM_LEN_WORD     = 2'd0;
    localparam logic [1:0] c_MEM_LEN_BYTE     = 2'd1;
    localparam logic [1:0] c_MEM_LEN_HALF     = 2'd2;
    localparam logic [1:0] c_MEM_LEN_WORD_ALT = 2'd3;

    // "type" is a reserved word, so the type field is named msg_type.
    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    // Responder FSM state encoding.
    typedef logic [1:0] state_t;
    localparam state_t c_STATE_IDLE = 2'd0;
    localparam state_t c_STATE_WAIT = 2'd1;
    localparam state_t c_STATE_RESP = 2'd2;

    // Random-delay LFSR: x^8 + x^6 + x^5 + x^4 + 1 in right-shifting Galois
    // form (maximal length, period 255).
    localparam logic [7:0] c_LFSR_SEED = 8'hA5;
    localparam logic [7:0] c_LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        lfsr_next = {1'b0, cur[7:1]} ^ (cur[0] ? c_LFSR_TAPS : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lab2_mem_responder_lfsr.sv
`default_nettype none
// ============================================================================
//  Module   : lab2_mem_responder_lfsr
//  Purpose  : 8-bit maximal-length Galois LFSR used to add 0-3 random cycles
//             of latency per transaction. Only compiled when
//             LAB2_MEM_RESPONDER_RAND_DELAY_EN is defined.
//  Ports    : clk     - clock
//             rst     - synchronous active-high reset, loads c_LFSR_SEED
//             i_en    - advance one step
//             o_state - current LFSR value
//  Revision : 1.0 - initial release
// ============================================================================
`ifdef LAB2_MEM_RESPONDER_RAND_DELAY_EN
module lab2_mem_responder_lfsr
    import lab2_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    output logic [7:0] o_state
);

    logic [7:0] r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_LFSR_SEED;
        end else if (i_en) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule
`endif
`default_nettype wire

// File: rtl/lab2_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : lab2_mem_responder
//  Purpose  : Single-port memory responder for the imem/dmem val/rdy
//             interface. Performs word / halfword / byte reads and writes on
//             an internal word array and returns a response after a fixed
//             latency of p_latency cycles (plus 0-3 random cycles when
//             LAB2_MEM_RESPONDER_RAND_DELAY_EN is defined).
//  Params   : p_num_words - array depth in words (power of two)
//             p_latency   - accept-to-resp_val latency, >= 1
//  Ports    : clk, reset           - clock, synchronous active-high reset
//             req_val/req_rdy      - request handshake
//             req_msg              - mem_req_4B_t request
//             resp_val/resp_rdy    - response handshake
//             resp_msg             - mem_resp_4B_t response
//             err                  - sticky, set by an unsupported type
//  Macro    : LAB2_MEM_RESPONDER_RAND_DELAY_EN - enable random extra latency
//  Revision : 1.0 - initial release
// ============================================================================
module lab2_mem_responder
    import lab2_mem_pkg::*;
#(
    parameter int p_num_words = 256,
    parameter int p_latency   = 1
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         req_val,
    output logic         req_rdy,
    input  mem_req_4B_t  req_msg,
    output logic         resp_val,
    input  logic         resp_rdy,
    output mem_resp_4B_t resp_msg,
    output logic         err
);

    localparam int c_IDX_W = $clog2(p_num_words);
    // Wide enough to hold p_latency plus up to 3 random extra cycles.
    localparam int c_CNT_W = $clog2(p_latency + 4);
    localparam logic [c_CNT_W-1:0] c_BASE_LAT = c_CNT_W'(p_latency);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [c_CNT_W-1:0] r_count;
    mem_resp_4B_t       r_resp_msg;
    logic               r_err;
    logic [31:0]        r_mem [p_num_words];

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_accept;

    assign req_rdy  = !reset && ((r_state == c_STATE_IDLE) ||
                                 ((r_state == c_STATE_RESP) && resp_rdy));
    assign w_accept = req_val && req_rdy;
    // Derived purely from the state register; never a function of resp_rdy.
    assign resp_val = (r_state == c_STATE_RESP);
    assign resp_msg = r_resp_msg;
    assign err      = r_err;

    // ------------------------------------------------------------------
    // Effective latency for the transaction being accepted
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] w_eff_lat;

`ifdef LAB2_MEM_RESPONDER_RAND_DELAY_EN
    logic [7:0] w_lfsr;
    logic       w_unused_lfsr;

    lab2_mem_responder_lfsr u_lfsr (
        .clk     (clk),
        .rst     (reset),
        .i_en    (w_accept),
        .o_state (w_lfsr)
    );

    // The value present at accept time picks this transaction's delay;
    // the LFSR then steps on the same edge.
    assign w_eff_lat     = c_BASE_LAT + c_CNT_W'(w_lfsr[1:0]);
    assign w_unused_lfsr = ^w_lfsr[7:2];
`else
    assign w_eff_lat = c_BASE_LAT;
`endif

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [c_IDX_W-1:0] w_idx;
    logic [1:0]         w_off;
    logic               w_is_read;
    logic               w_is_write;
    logic               w_is_bad;
    logic               w_unused_addr;

    // Upper address bits are dropped so addresses wrap around the array.
    assign w_idx         = req_msg.addr[c_IDX_W+1:2];
    assign w_off         = req_msg.addr[1:0];
    assign w_unused_addr = ^req_msg.addr[31:c_IDX_W+2];

    assign w_is_read  = (req_msg.msg_type == c_MEM_TYPE_READ);
    assign w_is_write = (req_msg.msg_type == c_MEM_TYPE_WRITE) ||
                        (req_msg.msg_type == c_MEM_TYPE_WRITE_INIT);
    assign w_is_bad   = !w_is_read && !w_is_write;

    // ------------------------------------------------------------------
    // Byte-lane write enables; write data is replicated across lanes so
    // the low bits of req data land in whichever lanes are enabled.
    // ------------------------------------------------------------------
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = req_msg.data;
        case (req_msg.len)
            c_MEM_LEN_BYTE: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{req_msg.data[7:0]}};
            end
            c_MEM_LEN_HALF: begin
                // addr[0] is ignored for halfwords
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req_msg.data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = req_msg.data;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read-data alignment: selected bytes shifted down and zero-extended
    // ------------------------------------------------------------------
    logic [31:0] w_word;
    logic [31:0] w_shifted;
    logic [31:0] w_rdata;

    assign w_word    = r_mem[w_idx];
    assign w_shifted = w_word >> {w_off, 3'b000};

    always_comb begin
        w_rdata = w_word;
        case (req_msg.len)
            c_MEM_LEN_BYTE: w_rdata = {24'h000000, w_shifted[7:0]};
            c_MEM_LEN_HALF: w_rdata = {16'h0000,
                                       w_off[1] ? w_word[31:16] : w_word[15:0]};
            default:        w_rdata = w_word;
        endcase
    end

    // ------------------------------------------------------------------
    // Response message built at accept time
    // ------------------------------------------------------------------
    mem_resp_4B_t w_resp_next;

    always_comb begin
        w_resp_next          = '0;
        w_resp_next.msg_type = req_msg.msg_type;
        w_resp_next.opaque   = req_msg.opaque;
        w_resp_next.test     = 2'd0;
        w_resp_next.len      = req_msg.len;
        w_resp_next.data     = w_is_read ? w_rdata : 32'h0000_0000;
    end

    // ------------------------------------------------------------------
    // Word array: not reset. Writes land on the accept edge so a read
    // accepted on the following edge already sees the new data.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept && w_is_write) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_STATE_IDLE;
            r_count    <= '0;
            r_resp_msg <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_resp_msg <= w_resp_next;
                if (w_is_bad) begin
                    r_err <= 1'b1;
                end
            end

            // An accept can only happen in IDLE or in RESP while the
            // current response is being consumed, so it always starts a
            // fresh transaction.
            if (w_accept) begin
                r_count <= w_eff_lat;
                r_state <= (w_eff_lat == c_CNT_W'(1)) ? c_STATE_RESP
                                                      : c_STATE_WAIT;
            end else begin
                case (r_state)
                    c_STATE_IDLE: begin
                        r_state <= c_STATE_IDLE;
                    end
                    c_STATE_WAIT: begin
                        r_count <= r_count - c_CNT_W'(1);
                        // Counter is about to reach 1: response is due.
                        if (r_count <= c_CNT_W'(2)) begin
                            r_state <= c_STATE_RESP;
                        end
                    end
                    c_STATE_RESP: begin
                        if (resp_rdy) begin
                            r_state <= c_STATE_IDLE;
                        end
                    end
                    default: begin
                        r_state <= c_STATE_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lab2_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lab2_mem_responder
//  Purpose  : Directed self-checking bench. Instance A uses p_latency=1,
//             instance B uses p_latency=4; a select steers the shared
//             request/response signals to one of them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lab2_mem_responder;
    import lab2_mem_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         sel;
    logic         req_val;
    logic         resp_rdy;
    mem_req_4B_t  req_msg;

    logic         a_req_val, b_req_val;
    logic         a_req_rdy, b_req_rdy;
    logic         a_resp_val, b_resp_val;
    logic         a_err, b_err;
    mem_resp_4B_t a_resp_msg, b_resp_msg;

    logic         req_rdy;
    logic         resp_val;
    logic         err;
    mem_resp_4B_t resp_msg;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] d;

    always #5 clk = ~clk;

    assign a_req_val = req_val && !sel;
    assign b_req_val = req_val && sel;
    assign req_rdy   = sel ? b_req_rdy  : a_req_rdy;
    assign resp_val  = sel ? b_resp_val : a_resp_val;
    assign resp_msg  = sel ? b_resp_msg : a_resp_msg;
    assign err       = sel ? b_err      : a_err;

    lab2_mem_responder #(.p_num_words(256), .p_latency(1)) u_dut_a (
        .clk      (clk),
        .reset    (reset),
        .req_val  (a_req_val),
        .req_rdy  (a_req_rdy),
        .req_msg  (req_msg),
        .resp_val (a_resp_val),
        .resp_rdy (resp_rdy),
        .resp_msg (a_resp_msg),
        .err      (a_err)
    );

    lab2_mem_responder #(.p_num_words(256), .p_latency(4)) u_dut_b (
        .clk      (clk),
        .reset    (reset),
        .req_val  (b_req_val),
        .req_rdy  (b_req_rdy),
        .req_msg  (req_msg),
        .resp_val (b_resp_val),
        .resp_rdy (resp_rdy),
        .resp_msg (b_resp_msg),
        .err      (b_err)
    );

    task automatic check_vec(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request from a negedge, wait lat cycles for the response,
    // check the echoed fields and return the response data.
    task automatic xact(input string tag, input logic [2:0] t,
                        input logic [7:0] op, input logic [31:0] addr,
                        input logic [1:0] len, input logic [31:0] data,
                        input int lat, output logic [31:0] rdata);
        int n;
        req_msg = '{msg_type: t, opaque: op, addr: addr, len: len, data: data};
        req_val = 1'b1;
        n = 0;
        while (!req_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_vec({tag, "_rdy"}, {63'd0, req_rdy}, 64'd1);
        @(negedge clk);
        req_val = 1'b0;
        for (int i = 1; i < lat; i++) begin
            check_vec({tag, "_early"}, {63'd0, resp_val}, 64'd0);
            @(negedge clk);
        end
        check_vec({tag, "_val"},    {63'd0, resp_val},          64'd1);
        check_vec({tag, "_type"},   {61'd0, resp_msg.msg_type}, {61'd0, t});
        check_vec({tag, "_opaque"}, {56'd0, resp_msg.opaque},   {56'd0, op});
        check_vec({tag, "_len"},    {62'd0, resp_msg.len},      {62'd0, len});
        check_vec({tag, "_test"},   {62'd0, resp_msg.test},     64'd0);
        rdata = resp_msg.data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        req_val  = 1'b0;
        resp_rdy = 1'b1;
        sel      = 1'b0;
        req_msg  = '0;
        repeat (2) @(negedge clk);
        check_vec("rst_rdy_low", {63'd0, req_rdy}, 64'd0);
        reset = 1'b0;
        #1;
        check_vec("rst_val_a", {63'd0, a_resp_val}, 64'd0);
        check_vec("rst_val_b", {63'd0, b_resp_val}, 64'd0);
        check_vec("rst_msg_a", {17'd0, a_resp_msg}, 64'd0);
        check_vec("rst_err_a", {63'd0, a_err},      64'd0);
        check_vec("rst_rdy_a", {63'd0, req_rdy},    64'd1);
        @(negedge clk);

        // ---------------- write then read, latency 1 ----------------
        xact("wr100", c_MEM_TYPE_WRITE, 8'h11, 32'h100, 2'd0, 32'hDEADBEEF, 1, d);
        check_vec("wr100_data", {32'd0, d}, 64'd0);
        xact("rd100", c_MEM_TYPE_READ, 8'h22, 32'h100, 2'd0, 32'h0, 1, d);
        check_vec("rd100_data", {32'd0, d}, 64'hDEADBEEF);

        // ---------------- subword ----------------
        xact("wi200", c_MEM_TYPE_WRITE_INIT, 8'h01, 32'h200, 2'd0, 32'h11223344, 1, d);
        xact("wb201", c_MEM_TYPE_WRITE, 8'h02, 32'h201, 2'd1, 32'hFFFFFFAA, 1, d);
        xact("rh202", c_MEM_TYPE_READ, 8'h03, 32'h202, 2'd2, 32'h0, 1, d);
        check_vec("rh202_data", {32'd0, d}, 64'h1122);
        xact("rw200", c_MEM_TYPE_READ, 8'h04, 32'h200, 2'd0, 32'h0, 1, d);
        check_vec("rw200_data", {32'd0, d}, 64'h1122AA44);
        xact("rb203", c_MEM_TYPE_READ, 8'h05, 32'h203, 2'd1, 32'h0, 1, d);
        check_vec("rb203_data", {32'd0, d}, 64'h11);
        xact("rh201", c_MEM_TYPE_READ, 8'h06, 32'h201, 2'd2, 32'h0, 1, d);
        check_vec("rh201_data", {32'd0, d}, 64'hAA44);
        xact("rl3", c_MEM_TYPE_READ, 8'h07, 32'h200, 2'd3, 32'h0, 1, d);
        check_vec("rl3_data", {32'd0, d}, 64'h1122AA44);

        // ---------------- back-pressure ----------------
        req_val = 1'b0;
        @(negedge clk);
        resp_rdy = 1'b0;
        req_msg  = '{msg_type: c_MEM_TYPE_READ, opaque: 8'h33, addr: 32'h100,
                     len: 2'd0, data: 32'h0};
        req_val  = 1'b1;
        @(negedge clk);
        req_msg  = '{msg_type: c_MEM_TYPE_READ, opaque: 8'h34, addr: 32'h200,
                     len: 2'd0, data: 32'h0};
        for (int i = 0; i < 5; i++) begin
            check_vec("bp_val",    {63'd0, resp_val},        64'd1);
            check_vec("bp_opaque", {56'd0, resp_msg.opaque}, 64'h33);
            check_vec("bp_data",   {32'd0, resp_msg.data},   64'hDEADBEEF);
            check_vec("bp_rdy",    {63'd0, req_rdy},         64'd0);
            @(negedge clk);
        end
        resp_rdy = 1'b1;
        #1;
        check_vec("bp_release_rdy", {63'd0, req_rdy}, 64'd1);
        @(negedge clk);
        req_val = 1'b0;
        check_vec("bp_next_val",    {63'd0, resp_val},        64'd1);
        check_vec("bp_next_opaque", {56'd0, resp_msg.opaque}, 64'h34);
        check_vec("bp_next_data",   {32'd0, resp_msg.data},   64'h1122AA44);
        @(negedge clk);

        // ---------------- streaming, 8 back-to-back reads ----------------
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) begin
                check_vec("st_val",    {63'd0, resp_val},        64'd1);
                check_vec("st_opaque", {56'd0, resp_msg.opaque}, 64'(k - 1));
                check_vec("st_data",   {32'd0, resp_msg.data},
                          ((k - 1) % 2 == 1) ? 64'h1122AA44 : 64'hDEADBEEF);
            end
            if (k < 8) begin
                req_msg = '{msg_type: c_MEM_TYPE_READ, opaque: 8'(k),
                            addr: (k % 2 == 1) ? 32'h200 : 32'h100,
                            len: 2'd0, data: 32'h0};
                req_val = 1'b1;
                check_vec("st_rdy", {63'd0, req_rdy}, 64'd1);
            end else begin
                req_val = 1'b0;
            end
            @(negedge clk);
        end
        check_vec("st_done", {63'd0, resp_val}, 64'd0);

        // ---------------- wrap and error ----------------
        xact("wr404", c_MEM_TYPE_WRITE, 8'h40, 32'h0000_0404, 2'd0, 32'hCAFEF00D, 1, d);
        xact("rd004", c_MEM_TYPE_READ, 8'h41, 32'h0000_0004, 2'd0, 32'h0, 1, d);
        check_vec("wrap_data", {32'd0, d}, 64'hCAFEF00D);
        check_vec("wrap_err", {63'd0, err}, 64'd0);
        xact("amo", c_MEM_TYPE_AMO_ADD, 8'h55, 32'h4, 2'd0, 32'h12345678, 1, d);
        check_vec("amo_data", {32'd0, d}, 64'd0);
        check_vec("amo_err", {63'd0, err}, 64'd1);
        xact("rd004b", c_MEM_TYPE_READ, 8'h56, 32'h4, 2'd0, 32'h0, 1, d);
        check_vec("amo_nomod", {32'd0, d}, 64'hCAFEF00D);
        check_vec("amo_sticky", {63'd0, err}, 64'd1);
        req_val = 1'b0;
        @(negedge clk);

        // ---------------- instance B, latency 4 ----------------
        sel = 1'b1;
        #1;
        xact("b_wr", c_MEM_TYPE_WRITE, 8'h60, 32'h100, 2'd0, 32'h55AA55AA, 4, d);
        xact("b_rd", c_MEM_TYPE_READ, 8'h61, 32'h100, 2'd0, 32'h0, 4, d);
        check_vec("b_rd_data", {32'd0, d}, 64'h55AA55AA);
        req_val = 1'b0;
        @(negedge clk);

        // write accepted, then reset two cycles later while in WAIT
        req_msg = '{msg_type: c_MEM_TYPE_WRITE, opaque: 8'h44, addr: 32'h300,
                    len: 2'd0, data: 32'h0BADCAFE};
        req_val = 1'b1;
        check_vec("mrst_acc_rdy", {63'd0, req_rdy}, 64'd1);
        @(negedge clk);
        req_val = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_vec("mrst_rdy",   {63'd0, req_rdy},  64'd1);
        check_vec("mrst_err",   {63'd0, err},      64'd0);
        check_vec("mrst_err_a", {63'd0, a_err},    64'd0);
        check_vec("mrst_val",   {63'd0, resp_val}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_vec("mrst_noresp", {63'd0, resp_val}, 64'd0);
        end
        xact("b_rd300", c_MEM_TYPE_READ, 8'h62, 32'h300, 2'd0, 32'h0, 4, d);
        check_vec("mrst_keep", {32'd0, d}, 64'h0BADCAFE);
        req_val = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
